cfg_burst_streamer: RTL and testbench

Sequencer that turns a window of the wide PS configuration bus into an ordered, handshaked AXI-Stream burst. On a commit edge it atomically snapshots NUM_WORDS consecutive 32-bit config words starting at word BASE_ADDR. It then emits them one per accepted beat, lowest word first, with tlast on the final word. It sits between the config register bank and downstream stream consumers that need a coherent multi-word parameter set rather than free-running, always-valid field taps.

---
 rtl/cfg_burst_streamer.sv | 157 +++++++++++++++
 tb/tb_cfg_burst_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_burst_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_burst_streamer
// Purpose  : Snapshots a window of NUM_WORDS consecutive 32-bit words from the
//            wide configuration bus on a commit rising edge, then replays them
//            as one AXI-Stream burst, lowest word first, tlast on the final word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   a_clk          in   1          clock, rising edge
//   a_resetn       in   1          asynchronous active-low reset
//   cfg            in   CFG_WIDTH  config bus, word i = cfg[i*32 +: 32]
//   commit         in   1          snapshot request (rising edge triggers)
//   M_AXIS_tdata   out  32         current burst word
//   M_AXIS_tvalid  out  1          beat valid
//   M_AXIS_tready  in   1          downstream accept
//   M_AXIS_tlast   out  1          final word of the burst
//   busy           out  1          burst in progress
//   overrun_count  out  16         dropped commit edges, saturating
// ============================================================================
module cfg_burst_streamer #(
    parameter int CFG_WIDTH = 1024,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 4
) (
    input  logic                 a_clk,
    input  logic                 a_resetn,
    input  logic [CFG_WIDTH-1:0] cfg,
    input  logic                 commit,
    output logic [31:0]          M_AXIS_tdata,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic                 M_AXIS_tlast,
    output logic                 busy,
    output logic [15:0]          overrun_count
);

    localparam int              IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      shadow_q [NUM_WORDS];
    logic [31:0]      shadow_d [NUM_WORDS];
    logic             commit_q;
    logic [15:0]      overrun_q, overrun_d;

    logic             commit_edge;
    logic             handshake;
    logic             last_beat;
    logic             snapshot;

    // commit held high through reset release still counts, because commit_q
    // comes out of reset at 0.
    assign commit_edge = commit & ~commit_q;
    assign handshake   = (state_q == ST_SEND) & M_AXIS_tready;
    assign last_beat   = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            commit_q  <= 1'b0;
            overrun_q <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            commit_q  <= commit;
            overrun_q <= overrun_d;
            for (int k = 0; k < NUM_WORDS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        snapshot  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (commit_edge) begin
                    snapshot = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake && last_beat) begin
                    // A commit landing on the final handshake chains straight
                    // into a fresh burst and is not an overrun.
                    if (commit_edge) begin
                        snapshot = 1'b1;
                        idx_d    = '0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    if (handshake) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (commit_edge && (overrun_q != 16'hFFFF)) begin
                        overrun_d = overrun_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Shadow capture: all words load on the same edge so the burst is coherent.
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            shadow_d[k] = shadow_q[k];
            if (snapshot) begin
                shadow_d[k] = cfg[(BASE_ADDR + k)*32 +: 32];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers only, gated to zero outside a burst.
    // ------------------------------------------------------------------------
    always_comb begin
        M_AXIS_tvalid = (state_q == ST_SEND);
        busy          = (state_q == ST_SEND);
        M_AXIS_tdata  = '0;
        M_AXIS_tlast  = 1'b0;
        if (state_q == ST_SEND) begin
            M_AXIS_tdata = shadow_q[idx_q];
            M_AXIS_tlast = last_beat;
        end
    end

    assign overrun_count = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_burst_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_burst_streamer
// Purpose  : Self-checking bench for cfg_burst_streamer (BASE_ADDR=2,
//            NUM_WORDS=4). Stimulus pushes hand-computed beats into a queue;
//            a monitor on the falling edge compares every presented beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_burst_streamer;

    localparam int CFG_WIDTH = 1024;
    localparam int BASE_ADDR = 2;
    localparam int NUM_WORDS = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic                 clk;
    logic                 a_resetn;
    logic [CFG_WIDTH-1:0] cfg;
    logic                 commit;
    logic [31:0]          tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;
    logic                 busy;
    logic [15:0]          overrun_count;

    beat_t exp_q[$];
    int    n_vec;
    int    n_err;

    cfg_burst_streamer #(
        .CFG_WIDTH (CFG_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .a_clk         (clk),
        .a_resetn      (a_resetn),
        .cfg           (cfg),
        .commit        (commit),
        .M_AXIS_tdata  (tdata),
        .M_AXIS_tvalid (tvalid),
        .M_AXIS_tready (tready),
        .M_AXIS_tlast  (tlast),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        cfg[idx*32 +: 32] = val;
    endtask

    task automatic push4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        beat_t bt;
        bt.data = a; bt.last = 1'b0; exp_q.push_back(bt);
        bt.data = b; bt.last = 1'b0; exp_q.push_back(bt);
        bt.data = c; bt.last = 1'b0; exp_q.push_back(bt);
        bt.data = d; bt.last = 1'b1; exp_q.push_back(bt);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic drain(input string name);
        tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every presented beat must match the queue head.
    always @(negedge clk) begin
        if (a_resetn && tvalid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got tdata %h with empty queue", tdata);
            end else begin
                chk("beat_tdata", tdata, exp_q[0].data);
                chk("beat_tlast", {31'd0, tlast}, {31'd0, exp_q[0].last});
                if (tready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        a_resetn = 1'b0;
        cfg      = '0;
        commit   = 1'b0;
        tready   = 1'b0;

        // ---------------- reset defaults ----------------
        repeat (5) tick();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {16'd0, overrun_count}, 32'd0);
        a_resetn = 1'b1;
        repeat (3) tick();
        chk("idle_tvalid", {31'd0, tvalid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- basic burst ----------------
        set_word(2, 32'h11111111);
        set_word(3, 32'h22222222);
        set_word(4, 32'h33333333);
        set_word(5, 32'h44444444);
        set_word(1, 32'hBAD0BAD0);
        set_word(6, 32'hBAD1BAD1);
        tready = 1'b1;
        push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        pulse_commit();
        chk("basic_busy_first", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("basic_busy_after", {31'd0, busy}, 32'd0);
        chk("basic_queue_empty", exp_q.size(), 32'd0);

        // ---------------- backpressure and coherence ----------------
        push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        pulse_commit();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tready = (i % 3 == 0);
            if (i == 1) set_word(3, 32'hDEADBEEF);
            tick();
        end
        chk("bp_busy_done", {31'd0, busy}, 32'd0);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // ---------------- overrun ----------------
        set_word(3, 32'h22222222);
        tready = 1'b1;
        push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        pulse_commit();
        tick();                 // first beat accepted
        tready = 1'b0;
        set_word(3, 32'h0BADF00D);
        repeat (3) begin
            pulse_commit();
            tick();
        end
        chk("ovr_count3", {16'd0, overrun_count}, 32'd3);
        chk("ovr_still_busy", {31'd0, busy}, 32'd1);
        drain("ovr");
        chk("ovr_count_hold", {16'd0, overrun_count}, 32'd3);

        // ---------------- overrun saturation ----------------
        set_word(3, 32'h22222222);
        force dut.overrun_q = 16'hFFFF;
        tick();
        release dut.overrun_q;
        tick();
        chk("sat_loaded", {16'd0, overrun_count}, 32'h0000FFFF);
        tready = 1'b0;
        push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        pulse_commit();
        repeat (2) begin
            pulse_commit();
            tick();
        end
        chk("sat_hold", {16'd0, overrun_count}, 32'h0000FFFF);
        drain("sat");

        // ---------------- back-to-back ----------------
        force dut.overrun_q = 16'd7;
        tick();
        release dut.overrun_q;
        tick();
        tready = 1'b1;
        push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        pulse_commit();
        repeat (3) tick();      // words 0..2 accepted, final word presented
        chk("b2b_last_presented", {31'd0, tlast}, 32'd1);
        set_word(2, 32'hA0000001);
        set_word(3, 32'hA0000002);
        set_word(4, 32'hA0000003);
        set_word(5, 32'hA0000004);
        push4(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
        pulse_commit();         // edge coincides with final handshake
        chk("b2b_tvalid_kept", {31'd0, tvalid}, 32'd1);
        chk("b2b_new_first", tdata, 32'hA0000001);
        repeat (4) tick();
        chk("b2b_busy_done", {31'd0, busy}, 32'd0);
        chk("b2b_overrun", {16'd0, overrun_count}, 32'd7);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);

        // ---------------- reset mid-burst ----------------
        set_word(2, 32'h55555555);
        set_word(3, 32'h66666666);
        set_word(4, 32'h77777777);
        set_word(5, 32'h88888888);
        push4(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
        pulse_commit();
        repeat (2) tick();      // two beats accepted
        a_resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("mid_rst_tdata", tdata, 32'd0);
        chk("mid_rst_overrun", {16'd0, overrun_count}, 32'd0);
        repeat (2) tick();
        a_resetn = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", {31'd0, tvalid}, 32'd0);
        push4(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
        pulse_commit();
        chk("post_rst_first", tdata, 32'h55555555);
        drain("post_rst");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
